// File: rtl/serial_borrow_subtractor_64_pkg.sv
// Shared definitions for the serial borrow subtractor: FSM encoding and default sizes.
package serial_borrow_subtractor_64_pkg;
   localparam int WIDTH_DEF = 64;
   localparam int CHUNK_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/borrow_chunk_sub.sv
// Combinational CHUNK-bit ripple-borrow subtractor slice: {bout, d} = a - b - bin.
module borrow_chunk_sub #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);
   logic [CHUNK:0] br;

   assign br[0] = bin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fs
      assign d[i]    = a[i] ^ b[i] ^ br[i];
      assign br[i+1] = (~a[i] & (b[i] | br[i])) | (b[i] & br[i]);
   end

   assign bout = br[CHUNK];
endmodule

// File: rtl/serial_borrow_subtractor_64.sv
// Multi-cycle subtractor, CHUNK bits per clock, LSB chunk first, start/busy/done handshake.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_borrow_subtractor_64
   import serial_borrow_subtractor_64_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             bin,
   output logic [WIDTH-1:0] out,
   output logic             bout,
   output logic             busy,
`ifdef SUB_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             done
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, out_q;
   logic             brw_q, bout_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;
   logic [CHUNK-1:0] diff_d;
   logic             brw_d;

   borrow_chunk_sub #(.CHUNK(CHUNK)) u_slice (
      .a    (a_q[cnt_q*CHUNK +: CHUNK]),
      .b    (b_q[cnt_q*CHUNK +: CHUNK]),
      .bin  (brw_q),
      .d    (diff_d),
      .bout (brw_d)
   );

`ifdef SUB_OVERFLOW_EN
   logic ovf_q;
   assign ovf = ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= in1;
                  b_q     <= in2;
                  brw_q   <= bin;
                  cnt_q   <= '0;
                  out_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
`ifdef SUB_OVERFLOW_EN
                  ovf_q   <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               out_q[cnt_q*CHUNK +: CHUNK] <= diff_d;
               brw_q <= brw_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= S_DONE;
                  bout_q  <= brw_d;
                  done_q  <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                  // diff_d[CHUNK-1] is the result MSB produced this cycle
                  ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (diff_d[CHUNK-1] != a_q[WIDTH-1]);
`endif
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign out  = out_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_serial_borrow_subtractor_64.sv
// Bench for serial_borrow_subtractor_64: directed table, handshake corner cases, random back-to-back run.
module tb_serial_borrow_subtractor_64;
   logic        clk, rst, start, bin;
   logic [63:0] in1, in2, out;
   logic        bout, busy, done;
`ifdef SUB_OVERFLOW_EN
   logic        ovf;
`endif

   serial_borrow_subtractor_64 dut (
      .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .bin(bin),
      .out(out), .bout(bout), .busy(busy),
`ifdef SUB_OVERFLOW_EN
      .ovf(ovf),
`endif
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] out;
      logic        bout;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        bi;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   vec_t vt[7];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
      exp_t        e;
      logic [64:0] r;
      r      = {1'b0, a} - {1'b0, b} - {64'd0, bi};
      e.out  = r[63:0];
      e.bout = r[64];
      e.ovf  = (a[63] != b[63]) && (r[63] != a[63]);
      return e;
   endfunction

   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_sb_empty: got done with no expected entry, expected queued result", tag);
      end else begin
         e = sb.pop_front();
         cmp({tag, "_out"}, out, e.out);
         cmp({tag, "_bout"}, {63'd0, bout}, {63'd0, e.bout});
`ifdef SUB_OVERFLOW_EN
         cmp({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
`endif
      end
   endtask

   // waits for done at negedges; returns number of negedges elapsed (bounded)
   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < 40);
   endtask

   task automatic drive_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic bi, input exp_t e);
      int cyc;
      @(negedge clk);
      in1 = a; in2 = b; bin = bi; start = 1'b1;
      sb.push_back(e);
      wait_done(cyc);
      start = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: done not seen in %0d cycles, expected 9", tag, cyc);
         void'(sb.pop_front());
      end else begin
         cmp({tag, "_latency"}, 64'(cyc), 64'd9);
         check_result(tag);
         @(negedge clk);
         cmp({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
         cmp({tag, "_out_hold"}, out, e.out);
      end
   endtask

   initial begin
      int   cyc, pulses;
      exp_t e;
      logic [63:0] ra, rb;
      logic        rbi;

      vt[0] = '{64'd1036, 64'd414, 1'b0, '{64'd622, 1'b0, 1'b0}};
      vt[1] = '{64'd0, 64'd1, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}};
      vt[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, '{64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b1}};
      vt[3] = '{64'd5, 64'd5, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}};
      vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}};
      vt[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '{64'h8000_0000_0000_0000, 1'b1, 1'b1}};
      vt[6] = '{64'h0123_4567_89AB_CDEF, 64'h100, 1'b0, '{64'h0123_4567_89AB_CCEF, 1'b0, 1'b0}};

      rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      cmp("rst_out", out, 64'd0);
      cmp("rst_bout", {63'd0, bout}, 64'd0);
      cmp("rst_busy", {63'd0, busy}, 64'd0);
      cmp("rst_done", {63'd0, done}, 64'd0);
`ifdef SUB_OVERFLOW_EN
      cmp("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         drive_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bi, vt[i].e);

      // start re-pulsed mid-RUN and operands disturbed: one done, original result
      @(negedge clk);
      in1 = 64'd100; in2 = 64'd30; bin = 1'b0; start = 1'b1;
      sb.push_back('{64'd70, 1'b0, 1'b0});
      @(negedge clk); start = 1'b0;
      cmp("busy_run", {63'd0, busy}, 64'd1);
      repeat (2) @(negedge clk);
      start = 1'b1; in1 = 64'd999; in2 = 64'd1; bin = 1'b1;
      @(negedge clk); start = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            check_result("busy_start");
         end
      end
      cmp("busy_start_pulses", 64'(pulses), 64'd1);
      if (pulses == 0) void'(sb.pop_front());

      // reset in the middle of RUN aborts without done
      @(negedge clk);
      in1 = 64'hFFFF_FFFF_FFFF_FFFF; in2 = 64'd0; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      cmp("abort_out", out, 64'd0);
      cmp("abort_busy", {63'd0, busy}, 64'd0);
      cmp("abort_done", {63'd0, done}, 64'd0);
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      cmp("abort_no_done", 64'(pulses), 64'd0);
      drive_op("after_abort", 64'd1036, 64'd414, 1'b1, '{64'd621, 1'b0, 1'b0});

      // random back-to-back with start held high
      @(negedge clk);
      in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; bin = 1'($urandom);
      start = 1'b1;
      sb.push_back(model(in1, in2, bin));
      for (int i = 0; i < 1000; i++) begin
         wait_done(cyc);
         if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL rnd%0d_timeout: done not seen in %0d cycles, expected %0d", i, cyc, (i == 0) ? 9 : 10);
            break;
         end
         cmp($sformatf("rnd%0d_period", i), 64'(cyc), (i == 0) ? 64'd9 : 64'd10);
         check_result($sformatf("rnd%0d", i));
         if (i < 999) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rbi = 1'($urandom);
            case ($urandom_range(0, 7))
               0: rb = ra;
               1: ra = 64'd0;
               2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
               default: ;
            endcase
            in1 = ra; in2 = rb; bin = rbi;
            sb.push_back(model(ra, rb, rbi));
         end else begin
            start = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
